// File: rtl/bsg_manycore_endpoint_tx_pkg.sv
// Shared manycore packet-width helpers and credit-state encoding
// for the endpoint transmit path.
package bsg_manycore_endpoint_tx_pkg;

    // Default coordinate width; every real instance overrides it.
    localparam int bsg_inv_width_gp = 1;

    localparam int bsg_manycore_op_width_gp = 2;
    localparam int bsg_manycore_ret_type_width_gp = 2;

    typedef enum logic [1:0] {
        CREDIT_IDLE    = 2'd0,
        CREDIT_ACTIVE  = 2'd1,
        CREDIT_STALLED = 2'd2
    } credit_state_e;

    function automatic int bsg_manycore_packet_width(
        input int addr_w,
        input int data_w,
        input int x_w,
        input int y_w
    );
        return bsg_manycore_op_width_gp + bsg_manycore_ret_type_width_gp
             + addr_w + data_w + 2 * (x_w + y_w);
    endfunction

    function automatic int bsg_manycore_return_packet_width(
        input int data_w,
        input int x_w,
        input int y_w
    );
        return bsg_manycore_ret_type_width_gp + data_w + x_w + y_w;
    endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry valid/ready FIFO; ready_o depends only on occupancy,
// and a written entry is visible on data_o from the next cycle.
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic [1:0]         count_r;
    logic               wptr_r;
    logic               rptr_r;
    logic               enq;
    logic               deq;

    assign ready_o = (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = mem_r[rptr_r];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= 2'd0;
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
        end else begin
            if (enq) wptr_r <= ~wptr_r;
            if (deq) rptr_r <= ~rptr_r;
            unique case ({enq, deq})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone qualifies it.
    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_endpoint_tx.sv
// Manycore endpoint transmit side: buffered requests, credit tracking,
// registered returns. Define BSG_MANYCORE_ENDPOINT_TX_CREDIT_ERR_EN for error_o.
module bsg_manycore_endpoint_tx
    import bsg_manycore_endpoint_tx_pkg::*;
#(
    parameter int x_cord_width_p    = bsg_inv_width_gp,
    parameter int y_cord_width_p    = bsg_inv_width_gp,
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 32,
    parameter int max_out_credits_p = 16,
    localparam int packet_width_lp =
        bsg_manycore_packet_width(addr_width_p, data_width_p,
                                  x_cord_width_p, y_cord_width_p),
    localparam int return_packet_width_lp =
        bsg_manycore_return_packet_width(data_width_p,
                                         x_cord_width_p, y_cord_width_p),
    localparam int credit_width_lp = $clog2(max_out_credits_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [packet_width_lp-1:0]        packet_i,
    input  logic                              v_i,
    output logic                              ready_o,
    output logic [packet_width_lp-1:0]        packet_o,
    output logic                              v_o,
    input  logic                              ready_i,
    input  logic                              return_v_i,
    input  logic [return_packet_width_lp-1:0] return_data_i,
    output logic                              return_v_r_o,
    output logic [return_packet_width_lp-1:0] return_data_r_o,
    output logic [credit_width_lp-1:0]        out_credits_o,
    output logic                              idle_o,
    output logic                              error_o
);

    localparam logic [credit_width_lp-1:0] max_credits_lp =
        credit_width_lp'(max_out_credits_p);
    localparam logic [credit_width_lp-1:0] one_lp = credit_width_lp'(1);

    logic [credit_width_lp-1:0] credits_r;
    logic [credit_width_lp-1:0] credits_n;
    credit_state_e              credit_state;
    logic                       fifo_ready;
    logic                       fifo_v;
    logic                       accept;

    bsg_two_fifo #(
        .width_p (packet_width_lp)
    ) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .ready_o (fifo_ready),
        .data_i  (packet_i),
        .v_i     (accept),
        .v_o     (fifo_v),
        .data_o  (packet_o),
        .yumi_i  (fifo_v & ready_i)
    );

    always_comb begin
        credit_state = CREDIT_ACTIVE;
        if (credits_r == max_credits_lp) credit_state = CREDIT_IDLE;
        else if (credits_r == '0)        credit_state = CREDIT_STALLED;
    end

    assign ready_o       = fifo_ready & (credit_state != CREDIT_STALLED);
    assign accept        = v_i & ready_o;
    assign v_o           = fifo_v;
    assign out_credits_o = credits_r;
    assign idle_o        = (credit_state == CREDIT_IDLE) & ~fifo_v;

    // A return with all credits already home saturates instead of wrapping.
    always_comb begin
        credits_n = credits_r;
        unique case ({accept, return_v_i})
            2'b10: credits_n = credits_r - one_lp;
            2'b01: begin
                if (credits_r != max_credits_lp) credits_n = credits_r + one_lp;
            end
            default: credits_n = credits_r;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) credits_r <= max_credits_lp;
        else         credits_r <= credits_n;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            return_v_r_o    <= 1'b0;
            return_data_r_o <= '0;
        end else begin
            return_v_r_o    <= return_v_i;
            return_data_r_o <= return_data_i;
        end
    end

`ifdef BSG_MANYCORE_ENDPOINT_TX_CREDIT_ERR_EN
    logic error_r;
    logic overflow;

    assign overflow = return_v_i & ~accept & (credits_r == max_credits_lp);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)       error_r <= 1'b0;
        else if (overflow) error_r <= 1'b1;
    end

    assign error_o = error_r;
`else
    assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_manycore_endpoint_tx.sv
// Self-checking bench for bsg_manycore_endpoint_tx with four credits.
// Table rows drive one cycle each; a queue tracks packets in flight.
module tb_bsg_manycore_endpoint_tx;
    import bsg_manycore_endpoint_tx_pkg::*;

    localparam int XW = 4;
    localparam int YW = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MC = 4;
    localparam int PW = bsg_manycore_packet_width(AW, DW, XW, YW);
    localparam int RW = bsg_manycore_return_packet_width(DW, XW, YW);
    localparam int CW = $clog2(MC + 1);

    logic          clk = 1'b0;
    logic          reset_i;
    logic [PW-1:0] packet_i;
    logic          v_i;
    logic          ready_o;
    logic [PW-1:0] packet_o;
    logic          v_o;
    logic          ready_i;
    logic          return_v_i;
    logic [RW-1:0] return_data_i;
    logic          return_v_r_o;
    logic [RW-1:0] return_data_r_o;
    logic [CW-1:0] out_credits_o;
    logic          idle_o;
    logic          error_o;

    always #5 clk = ~clk;

    bsg_manycore_endpoint_tx #(
        .x_cord_width_p    (XW),
        .y_cord_width_p    (YW),
        .data_width_p      (DW),
        .addr_width_p      (AW),
        .max_out_credits_p (MC)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .packet_i        (packet_i),
        .v_i             (v_i),
        .ready_o         (ready_o),
        .packet_o        (packet_o),
        .v_o             (v_o),
        .ready_i         (ready_i),
        .return_v_i      (return_v_i),
        .return_data_i   (return_data_i),
        .return_v_r_o    (return_v_r_o),
        .return_data_r_o (return_data_r_o),
        .out_credits_o   (out_credits_o),
        .idle_o          (idle_o),
        .error_o         (error_o)
    );

    typedef struct {
        bit       v;
        bit       rdy;
        bit       ret;
        bit [7:0] rdata;
        bit       e_ready;
        int       e_cr;
        bit       e_vo;
        bit       e_idle;
    } vec_t;

    int            total = 0;
    int            bad = 0;
    int            seq = 1;
    bit            err_en;
    bit            err_exp = 1'b0;
    bit            prev_ret = 1'b0;
    logic [RW-1:0] prev_data = '0;
    logic [PW-1:0] sb [$];
    vec_t          tab_c [$];
    vec_t          tab_b [$];
    vec_t          tab_a [$];

    function automatic vec_t mk(bit v, bit rdy, bit ret, bit [7:0] d,
                                bit er, int ec, bit evo, bit eidle);
        vec_t t;
        t.v = v; t.rdy = rdy; t.ret = ret; t.rdata = d;
        t.e_ready = er; t.e_cr = ec; t.e_vo = evo; t.e_idle = eidle;
        return t;
    endfunction

    function automatic logic [PW-1:0] mkpkt(int s);
        logic [31:0] sv;
        sv = s;
        return {sv[19:0], 32'hCAFE0000 | sv, sv * 32'd3};
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step(vec_t t);
        @(negedge clk);
        v_i           = t.v;
        ready_i       = t.rdy;
        return_v_i    = t.ret;
        return_data_i = RW'(t.rdata);
        packet_i      = mkpkt(seq);
        #1;
        chk("ready_o", ready_o, t.e_ready);
        chk("credits", out_credits_o, t.e_cr);
        chk("v_o", v_o, t.e_vo);
        chk("idle_o", idle_o, t.e_idle);
        chk("error_o", error_o, err_exp);
        chk("return_v_r", return_v_r_o, prev_ret);
        if (prev_ret) chk("return_data_r", return_data_r_o, prev_data);
        if (t.e_vo) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL packet_o actual=%0h required=none", packet_o);
            end else begin
                chk("packet_o", packet_o, sb[0]);
                if (t.rdy) void'(sb.pop_front());
            end
        end
        if (t.v && t.e_ready) begin
            sb.push_back(packet_i);
            seq++;
        end
        if (err_en && t.ret && !(t.v && t.e_ready) && t.e_cr == MC)
            err_exp = 1'b1;
        prev_ret  = t.ret;
        prev_data = RW'(t.rdata);
    endtask

    initial begin
`ifdef BSG_MANYCORE_ENDPOINT_TX_CREDIT_ERR_EN
        err_en = 1'b1;
`else
        err_en = 1'b0;
`endif
        // exhaustion, return at zero, simultaneous accept+return at two
        tab_c.push_back(mk(1, 1, 0, 8'h00, 1, 4, 0, 1));
        tab_c.push_back(mk(1, 1, 0, 8'h00, 1, 3, 1, 0));
        tab_c.push_back(mk(1, 1, 0, 8'h00, 1, 2, 1, 0));
        tab_c.push_back(mk(1, 1, 0, 8'h00, 1, 1, 1, 0));
        tab_c.push_back(mk(1, 1, 0, 8'h00, 0, 0, 1, 0));
        tab_c.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0, 0));
        tab_c.push_back(mk(0, 1, 1, 8'h11, 0, 0, 0, 0));
        tab_c.push_back(mk(0, 1, 0, 8'h00, 1, 1, 0, 0));
        tab_c.push_back(mk(0, 1, 1, 8'h22, 1, 1, 0, 0));
        tab_c.push_back(mk(1, 1, 1, 8'h33, 1, 2, 0, 0));
        tab_c.push_back(mk(0, 1, 0, 8'h00, 1, 2, 1, 0));
        tab_c.push_back(mk(0, 1, 1, 8'h44, 1, 2, 0, 0));
        tab_c.push_back(mk(0, 1, 1, 8'h55, 1, 3, 0, 0));
        tab_c.push_back(mk(0, 1, 0, 8'h00, 1, 4, 0, 1));
        // backpressure, drain, then overflow return
        tab_b.push_back(mk(1, 0, 0, 8'h00, 1, 4, 0, 1));
        tab_b.push_back(mk(1, 0, 0, 8'h00, 1, 3, 1, 0));
        tab_b.push_back(mk(1, 0, 0, 8'h00, 0, 2, 1, 0));
        tab_b.push_back(mk(0, 0, 0, 8'h00, 0, 2, 1, 0));
        tab_b.push_back(mk(0, 1, 0, 8'h00, 0, 2, 1, 0));
        tab_b.push_back(mk(0, 1, 0, 8'h00, 1, 2, 1, 0));
        tab_b.push_back(mk(0, 0, 1, 8'h66, 1, 2, 0, 0));
        tab_b.push_back(mk(0, 0, 1, 8'h77, 1, 3, 0, 0));
        tab_b.push_back(mk(0, 0, 1, 8'h5A, 1, 4, 0, 1));
        tab_b.push_back(mk(0, 0, 0, 8'h00, 1, 4, 0, 1));
        // build up two buffered packets with one credit left
        tab_a.push_back(mk(1, 1, 0, 8'h00, 1, 4, 0, 1));
        tab_a.push_back(mk(1, 1, 0, 8'h00, 1, 3, 1, 0));
        tab_a.push_back(mk(1, 0, 0, 8'h00, 1, 2, 1, 0));
        tab_a.push_back(mk(0, 0, 0, 8'h00, 0, 1, 1, 0));

        reset_i       = 1'b1;
        v_i           = 1'b0;
        ready_i       = 1'b0;
        return_v_i    = 1'b0;
        return_data_i = '0;
        packet_i      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        chk("rst credits", out_credits_o, MC);
        chk("rst ready_o", ready_o, 1'b1);
        chk("rst idle_o", idle_o, 1'b1);
        chk("rst v_o", v_o, 1'b0);
        chk("rst error_o", error_o, 1'b0);
        chk("rst return_v_r", return_v_r_o, 1'b0);

        foreach (tab_c[i]) step(tab_c[i]);
        foreach (tab_b[i]) step(tab_b[i]);
        foreach (tab_a[i]) step(tab_a[i]);

        // asynchronous reset with packets buffered, checked before any edge
        @(negedge clk);
        v_i        = 1'b0;
        ready_i    = 1'b0;
        return_v_i = 1'b1;
        reset_i    = 1'b1;
        #2;
        chk("async v_o", v_o, 1'b0);
        chk("async credits", out_credits_o, MC);
        chk("async error_o", error_o, 1'b0);
        chk("async return_v_r", return_v_r_o, 1'b0);
        sb.delete();
        err_exp  = 1'b0;
        prev_ret = 1'b0;
        @(posedge clk);
        @(negedge clk);
        return_v_i = 1'b0;
        reset_i    = 1'b0;
        #1;
        chk("post credits", out_credits_o, MC);
        chk("post ready_o", ready_o, 1'b1);
        chk("post idle_o", idle_o, 1'b1);
        chk("post return_v_r", return_v_r_o, 1'b0);

        step(mk(1, 1, 0, 8'h00, 1, 4, 0, 1));
        step(mk(0, 1, 0, 8'h00, 1, 3, 1, 0));
        step(mk(0, 1, 1, 8'h99, 1, 3, 0, 0));
        step(mk(0, 1, 0, 8'h00, 1, 4, 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
